// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the two-requester memory arbiter:
//   DEF_ADDR_W / DEF_DATA_W : default address / data widths
//   arb_state_t             : arbiter FSM state encoding
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

endpackage : mem_arbiter_pkg

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin pick.
// Ports:
//   i_req[1:0] : request vector (bit n = requester n)
//   i_last     : requester granted most recently
//   o_valid    : at least one request present
//   o_winner   : index of the selected requester (meaningful when o_valid)
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_valid,
    output logic       o_winner
);

    always_comb begin
        o_valid  = |i_req;
        o_winner = 1'b0;
        case (i_req)
            2'b01:   o_winner = 1'b0;
            2'b10:   o_winner = 1'b1;
            // Contention: the requester that did not win last time goes first.
            2'b11:   o_winner = ~i_last;
            default: o_winner = 1'b0;
        endcase
    end

endmodule : rr_arb2

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates two requesters onto one single-ported memory with exactly one
// access in flight. A winner is chosen in IDLE, its request is issued to the
// memory for one cycle (ACCESS, with a one-cycle gnt pulse), and reads take one
// more cycle (RESP) to capture mem_rdata into that requester's rdata register,
// signalled by a one-cycle rvalid pulse.
// Ports:
//   clk, resetn                 : clock, synchronous active-low reset
//   req0/1, we0/1               : request and write flag per requester
//   addr0/1, wdata0/1           : address and write data per requester
//   gnt0/1                      : access accepted and issued (1-cycle pulse)
//   rvalid0/1, rdata0/1         : read result pulse and registered read data
//   mem_addr, mem_wdata, mem_we : shared memory request
//   mem_rdata                   : memory read data, valid one cycle after address
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        r_state,     w_state_next;
    logic              r_last,      w_last_next;
    logic              r_winner,    w_winner_next;
    logic              r_is_write,  w_is_write_next;
    logic [1:0]        r_gnt,       w_gnt_next;
    logic [1:0]        r_rvalid,    w_rvalid_next;
    logic [DATA_W-1:0] r_rdata0,    w_rdata0_next;
    logic [DATA_W-1:0] r_rdata1,    w_rdata1_next;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_next;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_next;
    logic              r_mem_we,    w_mem_we_next;

    logic              w_arb_valid;
    logic              w_arb_winner;

    rr_arb2 u_rr_arb2 (
        .i_req    ({req1, req0}),
        .i_last   (r_last),
        .o_valid  (w_arb_valid),
        .o_winner (w_arb_winner)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;    // requester 0 wins the first tie
            r_winner    <= 1'b0;
            r_is_write  <= 1'b0;
            r_gnt       <= 2'b00;
            r_rvalid    <= 2'b00;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_last      <= w_last_next;
            r_winner    <= w_winner_next;
            r_is_write  <= w_is_write_next;
            r_gnt       <= w_gnt_next;
            r_rvalid    <= w_rvalid_next;
            r_rdata0    <= w_rdata0_next;
            r_rdata1    <= w_rdata1_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_mem_we    <= w_mem_we_next;
        end
    end

    // gnt, mem_we and rvalid are registered pulses: they default to 0 and are
    // only set on the transition into the cycle where they must be visible.
    always_comb begin
        w_state_next     = r_state;
        w_last_next      = r_last;
        w_winner_next    = r_winner;
        w_is_write_next  = r_is_write;
        w_gnt_next       = 2'b00;
        w_rvalid_next    = 2'b00;
        w_rdata0_next    = r_rdata0;
        w_rdata1_next    = r_rdata1;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_mem_we_next    = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_winner_next    = w_arb_winner;
                    w_last_next      = w_arb_winner;
                    w_is_write_next  = w_arb_winner ? we1 : we0;
                    w_mem_addr_next  = w_arb_winner ? addr1 : addr0;
                    w_mem_wdata_next = w_arb_winner ? wdata1 : wdata0;
                    w_mem_we_next    = w_arb_winner ? we1 : we0;
                    w_gnt_next       = w_arb_winner ? 2'b10 : 2'b01;
                    w_state_next     = ACCESS;
                end
            end
            ACCESS: begin
                w_state_next = r_is_write ? IDLE : RESP;
            end
            RESP: begin
                // mem_rdata is valid now, one cycle after the address was issued.
                if (r_winner) begin
                    w_rdata1_next = mem_rdata;
                    w_rvalid_next = 2'b10;
                end else begin
                    w_rdata0_next = mem_rdata;
                    w_rvalid_next = 2'b01;
                end
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign gnt0      = r_gnt[0];
    assign gnt1      = r_gnt[1];
    assign rvalid0   = r_rvalid[0];
    assign rvalid1   = r_rvalid[1];
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;

endmodule : mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of requester and memory ports.
REQ-002 Parameter DATA_W, default 32, data width of requester and memory ports.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 req0 / req1  input  1  requester 0/1 wants a memory access.
REQ-006 we0 / we1  input  1  requester 0/1 access is a write (1) or read (0).
REQ-007 addr0 / addr1  input  ADDR_W  requester 0/1 byte address.
REQ-008 wdata0 / wdata1  input  DATA_W  requester 0/1 write data.
REQ-009 gnt0 / gnt1  output  1  one-cycle pulse: access accepted and issued to memory.
REQ-010 rvalid0 / rvalid1  output  1  one-cycle pulse: rdata0/rdata1 holds read result.
REQ-011 rdata0 / rdata1  output  DATA_W  registered read data for requester 0/1.
REQ-012 mem_addr  output  ADDR_W  shared memory address.
REQ-013 mem_wdata  output  DATA_W  shared memory write data.
REQ-014 mem_we  output  1  shared memory write enable.
REQ-015 mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_addr is presented with mem_we=0.

Function
REQ-016 FSM states IDLE, ACCESS, RESP; exactly one access in flight at any time.
REQ-017 IDLE: no req -> stay IDLE; any req -> pick winner, register winner addr/wdata/we onto mem_addr/mem_wdata/mem_we, set gnt of winner, go ACCESS.
REQ-018 Arbitration round-robin on 1-bit pointer last: both req -> grant requester != last; single req -> grant it; last <= winner on every grant.
REQ-019 ACCESS (cycle N+1 after IDLE decision at N): memory signals stable, gnt of winner high for this cycle only, mem_we high only in this cycle and only for writes.
REQ-020 ACCESS -> IDLE for writes; ACCESS -> RESP for reads.
REQ-021 RESP: capture mem_rdata into winner's rdata register, winner's rvalid high in following cycle (N+3) for one cycle; RESP -> IDLE.
REQ-022 Latency: read request sampled at N -> gnt at N+1 -> rvalid at N+3; write sampled at N -> gnt/mem_we at N+1; next arbitration at N+2 (write) or N+3 (read).
REQ-023 Requester holds req/we/addr/wdata stable until gnt seen; req still high when arbiter next in IDLE is a new request.
REQ-024 mem_addr/mem_wdata hold last issued values outside ACCESS; mem_we=0 outside ACCESS.
REQ-025 rdataX changes only on a read completing for requester X; other requester's rdata unchanged.
REQ-026 gnt0 & gnt1 never both high; rvalid0 & rvalid1 never both high.
REQ-027 Inputs of the non-granted requester ignored while not in IDLE.

Reset
REQ-028 resetn=0 at a rising edge: state IDLE, last=1 (requester 0 wins first tie), all outputs 0.
REQ-029 Reset mid-ACCESS or mid-RESP aborts the access: no gnt, rvalid or mem_we asserted after reset edge.
REQ-030 First arbitration possible in first cycle with resetn=1.

Structure
REQ-031 Shared package/header holds ADDR_W/DATA_W defaults and state encodings IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
REQ-032 One sub-module rr_arb2: combinational 2-way round-robin pick from req[1:0] and last; FSM, registers and muxing stay in mem_arbiter.

Verification
REQ-033 req0 read addr 0x10, mem_rdata=0xCAFE0001 at N+2 -> gnt0 at N+1, rvalid0 at N+3, rdata0=0xCAFE0001, rdata1 stays 0.
REQ-034 req1 write addr 0x20 data 0x12345678 -> mem_we=1, mem_addr=0x20, mem_wdata=0x12345678 for exactly one cycle with gnt1; no rvalid.
REQ-035 req0 and req1 held high continuously (reads) after reset -> grants alternate 0,1,0,1 every 3 cycles.
REQ-036 Only req1 held high for 3 writes -> gnt1 every 2 cycles, gnt0 never.
REQ-037 resetn low during RESP of read -> no rvalid, all outputs 0, next req0 served normally.
REQ-038 Every test: assert gnt/rvalid one-hot-or-zero and mem_we only in ACCESS.
